// File: rtl/param_lifo.sv
// Parametrised synchronous LIFO with registered pop data, push+pop exchange, empty bypass,
// combinational top-of-stack peek, occupancy flags and single-cycle overflow/underflow pulses.
module param_lifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  parameter  int AF_MARGIN  = 1,
  parameter  int AE_MARGIN  = 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] peek,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;

  // The write slot is mem[count]; the top entry is mem[count-1] (only read when non-empty).
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_wr_idx  = AW'(r_count);
  assign w_top_idx = AW'(r_count - CW'(1));

  // NOTE: storage has no reset; count alone defines which entries are live, so stale data is harmless.
  always_ff @(posedge clk) begin
    if (!clear && write) begin
      if (read && !w_empty) begin
        r_mem[w_top_idx] <= data_in;
      end else if (!read && !w_full) begin
        r_mem[w_wr_idx] <= data_in;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      if (clear) begin
        r_count <= '0;
      end else begin
        case ({write, read})
          2'b10: begin
            if (!w_full) r_count    <= r_count + CW'(1);
            else         r_overflow <= 1'b1;
          end
          2'b01: begin
            if (!w_empty) begin
              r_data_out <= r_mem[w_top_idx];
              r_count    <= r_count - CW'(1);
              r_valid    <= 1'b1;
            end else begin
              r_underflow <= 1'b1;
            end
          end
          2'b11: begin
            // Exchange swaps the top entry; on an empty stack the push data bypasses straight out.
            r_data_out <= w_empty ? data_in : r_mem[w_top_idx];
            r_valid    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign data_out     = r_data_out;
  assign valid_out    = r_valid;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= CW'(DEPTH - AF_MARGIN));
  assign almost_empty = (r_count <= CW'(AE_MARGIN));
  assign peek         = w_empty ? '0 : r_mem[w_top_idx];

endmodule

// File: tb/tb_param_lifo.sv
// Self-checking bench for param_lifo: directed scenarios plus randomized traffic against a
// queue-based stack model.
module tb_param_lifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int VW    = CW + 7 + 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [DW-1:0] peek;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  param_lifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_MARGIN (1),
    .AE_MARGIN (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .write       (write),
    .read        (read),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .peek        (peek),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a plain queue whose back is the top of the stack.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout  = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf   = 1'b0;
  logic          m_unf   = 1'b0;

  task automatic model_step(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    if (c) begin
      q.delete();
    end else if (w && !r) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end else if (r && !w) begin
      if (q.size() > 0) begin
        m_dout  = q.pop_back();
        m_valid = 1'b1;
      end else begin
        m_unf = 1'b1;
      end
    end else if (w && r) begin
      if (q.size() > 0) begin
        m_dout = q.pop_back();
        q.push_back(d);
      end else begin
        m_dout = d;
      end
      m_valid = 1'b1;
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    int n = q.size();
    logic [DW-1:0] top = (n == 0) ? '0 : q[n-1];
    return {CW'(n), n == DEPTH, n == 0, n >= DEPTH - 1, n <= 1,
            m_ovf, m_unf, m_valid, m_dout, top};
  endfunction

  // Drive one request on the falling edge, let the DUT and model take the rising edge,
  // then return the inputs to idle 1 ns later (outputs are sampled at that point).
  task automatic cycle(input logic c, input logic w, input logic r, input logic [DW-1:0] d);
    @(negedge clk);
    clear   = c;
    write   = w;
    read    = r;
    data_in = d;
    @(posedge clk);
    model_step(c, w, r, d);
    #1;
    clear = 1'b0;
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if ({count, empty, almost_empty, data_out, valid_out, overflow, underflow}
        !== {CW'(0), 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset: count=%0d empty=%b ae=%b dout=%h valid=%b ovf=%b unf=%b, want 0 1 1 00 0 0 0",
               count, empty, almost_empty, data_out, valid_out, overflow, underflow);
    end else n_pass++;
  endtask

  task automatic test_lifo_order();
    logic [DW-1:0] pushes [5] = '{8'h31, 8'h32, 8'h38, 8'h26, 8'h10};
    logic [DW-1:0] pops   [5] = '{8'h10, 8'h26, 8'h38, 8'h32, 8'h31};
    foreach (pushes[i]) cycle(1'b0, 1'b1, 1'b0, pushes[i]);
    n_total++;
    if (count !== CW'(5) || peek !== 8'h10) begin
      $display("FAIL lifo_fill: count=%0d peek=%h, want 5 10", count, peek);
    end else n_pass++;
    foreach (pops[i]) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      n_total++;
      if (data_out !== pops[i] || valid_out !== 1'b1 || count !== CW'(4 - i)) begin
        $display("FAIL lifo_pop%0d: dout=%h valid=%b count=%0d, want %h 1 %0d",
                 i, data_out, valid_out, count, pops[i], 4 - i);
      end else n_pass++;
    end
  endtask

  task automatic test_boundaries();
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 8) begin
        n_total++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          $display("FAIL full_8th: full=%b ovf=%b, want 1 0", full, overflow);
        end else n_pass++;
      end
    end
    n_total++;
    if (overflow !== 1'b1 || count !== CW'(8) || peek !== 8'h08) begin
      $display("FAIL overflow_9th: ovf=%b count=%0d peek=%h, want 1 8 08", overflow, count, peek);
    end else n_pass++;
    for (int i = 8; i >= 1; i--) begin
      cycle(1'b0, 1'b0, 1'b1, 8'h00);
      n_total++;
      if (data_out !== 8'(i) || valid_out !== 1'b1) begin
        $display("FAIL drain_%0d: dout=%h valid=%b, want %h 1", i, data_out, valid_out, 8'(i));
      end else n_pass++;
    end
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    n_total++;
    if (underflow !== 1'b1 || valid_out !== 1'b0 || data_out !== 8'h01 || count !== CW'(0)) begin
      $display("FAIL underflow_9th: unf=%b valid=%b dout=%h count=%0d, want 1 0 01 0",
               underflow, valid_out, data_out, count);
    end else n_pass++;
  endtask

  task automatic test_exchange_bypass();
    cycle(1'b0, 1'b1, 1'b0, 8'hAA);
    cycle(1'b0, 1'b1, 1'b0, 8'hBB);
    cycle(1'b0, 1'b1, 1'b1, 8'hCC);
    n_total++;
    if (data_out !== 8'hBB || valid_out !== 1'b1 || count !== CW'(2) || peek !== 8'hCC) begin
      $display("FAIL exchange: dout=%h valid=%b count=%0d peek=%h, want BB 1 2 CC",
               data_out, valid_out, count, peek);
    end else n_pass++;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b1, 8'h5A);
    n_total++;
    if (data_out !== 8'h5A || valid_out !== 1'b1 || count !== CW'(0) || underflow !== 1'b0) begin
      $display("FAIL bypass: dout=%h valid=%b count=%0d unf=%b, want 5A 1 0 0",
               data_out, valid_out, count, underflow);
    end else n_pass++;
  endtask

  task automatic test_thresholds_clear();
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
    n_total++;
    if (count !== CW'(7) || almost_full !== 1'b1 || full !== 1'b0) begin
      $display("FAIL almost_full: count=%0d af=%b full=%b, want 7 1 0", count, almost_full, full);
    end else n_pass++;
    cycle(1'b1, 1'b1, 1'b0, 8'hEE);
    n_total++;
    if (count !== CW'(0) || empty !== 1'b1 || valid_out !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL clear: count=%0d empty=%b valid=%b ovf=%b, want 0 1 0 0",
               count, empty, valid_out, overflow);
    end else n_pass++;
    cycle(1'b0, 1'b1, 1'b0, 8'h42);
    n_total++;
    if (count !== CW'(1) || almost_empty !== 1'b1 || peek !== 8'h42) begin
      $display("FAIL almost_empty: count=%0d ae=%b peek=%h, want 1 1 42", count, almost_empty, peek);
    end else n_pass++;
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
    cycle(1'b0, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    n_total++;
    if (count !== CW'(0) || data_out !== 8'h00 || empty !== 1'b1) begin
      $display("FAIL async_reset: count=%0d dout=%h empty=%b, want 0 00 1", count, data_out, empty);
    end else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic c, w, r;
    logic [VW-1:0] exp_v, got_v;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 39) == 0);
      if ((i % 64) < 32) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 3);
      end else begin
        w = ($urandom_range(0, 9) < 3);
        r = ($urandom_range(0, 9) < 7);
      end
      cycle(c, w, r, 8'($urandom));
      exp_v = model_vec();
      got_v = {count, full, empty, almost_full, almost_empty,
               overflow, underflow, valid_out, data_out, peek};
      n_total++;
      if (got_v !== exp_v) begin
        $display("FAIL random_%0d (c=%b w=%b r=%b): got cnt/f/e/af/ae/ovf/unf/v/dout/peek=%h, want %h",
                 i, c, w, r, got_v, exp_v);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lifo_order();
    test_boundaries();
    test_exchange_bypass();
    test_thresholds_clear();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
